divider_sequencer: RTL and testbench

DIVIDER_SEQUENCER -- requirements
Module: divider_sequencer

---
 rtl/divider_sequencer_pkg.sv | 19 +
 rtl/divider_sequencer_cas_row.sv | 41 ++++
 rtl/divider_sequencer.sv | 133 +++++++++++++
 tb/tb_divider_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/divider_sequencer_pkg.sv
// Shared definitions for the non-restoring divider sequencer: default operand
// width, FSM state encoding and the iteration-counter width helper.
package divider_sequencer_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2,
        FINISH  = 2'd3
    } state_e;

    // The counter must reach N itself, so it needs clog2(N+1) bits
    function automatic int countWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_sequencer_cas_row.sv
// Controlled add/subtract row: o_sum = i_a + i_m when i_sub=0, i_a - i_m when i_sub=1.
// Built as a ripple chain of full_adder cells with the carry-in tied to the mode bit.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module cas_row #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_m,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);
    logic [W-1:0] w_carry;
    logic [W-1:0] w_mx;

    assign w_carry[0] = i_sub;
    assign w_mx       = i_m ^ {W{i_sub}};

    for (genvar g = 0; g < W - 1; g++) begin : g_fa
        full_adder u_fa (
            .i_a   (i_a[g]),
            .i_b   (w_mx[g]),
            .i_cin (w_carry[g]),
            .o_sum (o_sum[g]),
            .o_cout(w_carry[g+1])
        );
    end

    // The sign bit's carry-out is never needed, so only its sum is formed
    assign o_sum[W-1] = i_a[W-1] ^ w_mx[W-1] ^ w_carry[W-1];

endmodule

// File: rtl/divider_sequencer.sv
// Sequential unsigned N-bit non-restoring divider: N iterations, one remainder
// correction step and a finish step that registers the results and pulses done.
module divider_sequencer
    import divider_sequencer_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);
    localparam int            CW        = countWidth(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_e        r_state;
    state_e        w_next;
    logic [N:0]    r_a;
    logic [N:0]    r_m;
    logic [N-1:0]  r_q;
    logic [CW-1:0] r_count;
    logic          r_dbzPend;
    logic          r_done;
    logic          r_dbz;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          w_zeroDiv;
    logic [N:0]    w_opA;
    logic [N:0]    w_sum;
    logic          w_sub;

    assign w_zeroDiv = (divisor == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // ITER feeds the shifted {A,Q} into the row; CORRECT reuses it in add mode
    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE);
        w_opA  = r_a;
        w_sub  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = w_zeroDiv ? FINISH : ITER;
            end
            ITER: begin
                w_opA = {r_a[N-1:0], r_q[N-1]};
                w_sub = ~r_a[N];
                if (r_count == LAST_ITER) w_next = CORRECT;
            end
            CORRECT: w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    cas_row #(.W(N + 1)) u_cas (
        .i_a  (w_opA),
        .i_m  (r_m),
        .i_sub(w_sub),
        .o_sum(w_sum)
    );

    // Divide-by-zero preloads Q/A with the final values so FINISH handles both paths alike
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_count   <= '0;
            r_dbzPend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        if (w_zeroDiv) begin
                            r_m       <= '0;
                            r_q       <= '1;
                            r_a       <= {1'b0, dividend};
                            r_dbzPend <= 1'b1;
                        end else begin
                            r_m       <= {1'b0, divisor};
                            r_q       <= dividend;
                            r_a       <= '0;
                            r_dbzPend <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    r_a     <= w_sum;
                    r_q     <= {r_q[N-2:0], ~w_sum[N]};
                    r_count <= r_count + 1'b1;
                end
                CORRECT: begin
                    if (r_a[N]) r_a <= w_sum;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
        end else begin
            r_done <= (r_state == FINISH);
            if (r_state == FINISH) begin
                r_quot <= r_q;
                r_rem  <= r_a[N-1:0];
                r_dbz  <= r_dbzPend;
            end
        end
    end

    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign quotient    = r_quot;
    assign remainder   = r_rem;

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: stimulus pushes expected results computed
// with plain / and %, and a monitor pops and compares on every done pulse.
module tb_divider_sequencer;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    divider_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           doneCyc;
    } exp_t;

    exp_t         sbQ[$];
    int           compared   = 0;
    int           mismatched = 0;
    logic [N-1:0] lastQ = '0;
    logic [N-1:0] lastR = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("quotient", 32'(quotient), 32'(e.q));
                checkOutput("remainder", 32'(remainder), 32'(e.r));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
                lastQ = e.q;
                lastR = e.r;
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] dd, input logic [N-1:0] dv, input bit expectAccept);
        exp_t e;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        if (expectAccept) begin
            if (dv == 0) begin
                e.q = '1;
                e.r = dd;
                e.dbz = 1'b1;
                e.doneCyc = cyc + 1 + 1;
            end else begin
                e.q = N'(int'(dd) / int'(dv));
                e.r = N'(int'(dd) % int'(dv));
                e.dbz = 1'b0;
                e.doneCyc = cyc + 1 + N + 2;
            end
            sbQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((sbQ.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 60) begin
            checkOutput("timeout", 32'd0, 32'd1);
            sbQ.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_quot", 32'(quotient), 32'd0);
        checkOutput("rst_rem", 32'(remainder), 32'd0);
        checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        applyStimulus(8'd100, 8'd7, 1);
        checkOutput("busy_running", 32'(busy), 32'd1);
        waitIdle();
        applyStimulus(8'd5, 8'd9, 1);     waitIdle();
        applyStimulus(8'd255, 8'd1, 1);   waitIdle();
        applyStimulus(8'd0, 8'd200, 1);   waitIdle();
        applyStimulus(8'd42, 8'd0, 1);    waitIdle();
        applyStimulus(8'd255, 8'd255, 1); waitIdle();

        repeat (5) @(negedge clk);
        checkOutput("hold_quot", 32'(quotient), 32'(lastQ));
        checkOutput("hold_rem", 32'(remainder), 32'(lastR));

        // Start while busy is ignored
        applyStimulus(8'd100, 8'd7, 1);
        repeat (2) @(negedge clk);
        applyStimulus(8'd9, 8'd3, 0);
        waitIdle();
        applyStimulus(8'd9, 8'd3, 1);
        waitIdle();

        // Start during the FINISH cycle is ignored
        applyStimulus(8'd50, 8'd5, 1);
        repeat (N + 1) @(negedge clk);
        checkOutput("busy_finish", 32'(busy), 32'd1);
        dividend = 8'd9; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("finish_start_ignored", 32'(busy), 32'd0);
        waitIdle();

        // Reset mid-iteration discards the operation
        applyStimulus(8'd100, 8'd7, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sbQ.delete();
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_quot", 32'(quotient), 32'd0);
        checkOutput("midrst_rem", 32'(remainder), 32'd0);
        // Start coincident with reset is ignored
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        checkOutput("rst_start_ignored", 32'(busy), 32'd0);
        repeat (N + 4) @(negedge clk);
        applyStimulus(8'd200, 8'd13, 1);
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] dd;
            logic [N-1:0] dv;
            dd = N'($urandom);
            dv = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            applyStimulus(dd, dv, 1);
            waitIdle();
        end

        repeat (4) @(negedge clk);
        checkOutput("queue_drained", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
